// File: rtl/window_3x3_generator_pkg.sv
// window_3x3_generator_pkg: shared defaults and the 3x3 window pixel-index map
package window_3x3_generator_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;

    // Window pixel numbering: 1..3 top row, 4..6 middle row, 7..9 bottom row
    localparam int PIX_TL = 1;
    localparam int PIX_TC = 2;
    localparam int PIX_TR = 3;
    localparam int PIX_ML = 4;
    localparam int PIX_C  = 5;
    localparam int PIX_MR = 6;
    localparam int PIX_BL = 7;
    localparam int PIX_BC = 8;
    localparam int PIX_BR = 9;

    // Maps a (window row, window column) pair, both 0..2, to its pixel number
    function automatic int pix_idx(input int row, input int col);
        return row * 3 + col + 1;
    endfunction

endpackage

// File: rtl/window_3x3_generator_if.sv
// window_3x3_generator_if: pixel stream in, nine-pixel window and frame pulse out
interface window_3x3_generator_if
    import window_3x3_generator_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_pixel;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] input_pixel_1;
    logic [DATA_WIDTH-1:0] input_pixel_2;
    logic [DATA_WIDTH-1:0] input_pixel_3;
    logic [DATA_WIDTH-1:0] input_pixel_4;
    logic [DATA_WIDTH-1:0] input_pixel_5;
    logic [DATA_WIDTH-1:0] input_pixel_6;
    logic [DATA_WIDTH-1:0] input_pixel_7;
    logic [DATA_WIDTH-1:0] input_pixel_8;
    logic [DATA_WIDTH-1:0] input_pixel_9;
    logic                  frame_done;

    modport master (
        output in_valid, in_pixel,
        input  out_valid, frame_done,
        input  input_pixel_1, input_pixel_2, input_pixel_3,
        input  input_pixel_4, input_pixel_5, input_pixel_6,
        input  input_pixel_7, input_pixel_8, input_pixel_9
    );

    modport slave (
        input  in_valid, in_pixel,
        output out_valid, frame_done,
        output input_pixel_1, input_pixel_2, input_pixel_3,
        output input_pixel_4, input_pixel_5, input_pixel_6,
        output input_pixel_7, input_pixel_8, input_pixel_9
    );
endinterface

// File: rtl/window_3x3_generator_line_buffer.sv
// line_buffer: one image line of storage, synchronous write, read returns pre-write contents
module line_buffer
    import window_3x3_generator_pkg::*;
#(
    parameter int DEPTH      = IMG_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // The read sees the old word at the written address, so one line shifts into the next
    assign o_rdata = r_mem[i_addr];

    // Store the incoming word; contents are never cleared, the row counter masks stale data
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
endmodule

// File: rtl/window_3x3_generator.sv
// window_3x3_generator: builds interior 3x3 windows from a raster pixel stream using two line buffers
module window_3x3_generator
    import window_3x3_generator_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    window_3x3_generator_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_win [1:9];
    logic                  r_out_valid;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] w_lb0_rd;
    logic [DATA_WIDTH-1:0] w_lb1_rd;
    logic [DATA_WIDTH-1:0] w_new [3];
    logic                  w_accept;
    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_interior;

    assign w_accept   = bus.in_valid;
    assign w_last_col = r_col == LAST_COL;
    assign w_last_row = r_row == LAST_ROW;
    assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_new[0]   = w_lb1_rd;
    assign w_new[1]   = w_lb0_rd;
    assign w_new[2]   = bus.in_pixel;

    line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (bus.in_pixel),
        .o_rdata (w_lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // Raster position of the next pixel to be accepted, wrapping at line and frame ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_col <= w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
        end
    end

    // Shift the window left one column per accept; the new right column is {line r-2, line r-1, pixel}
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i <= 9; i++) r_win[i] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < 3; k++) begin
                r_win[pix_idx(k, 0)] <= r_win[pix_idx(k, 1)];
                r_win[pix_idx(k, 1)] <= r_win[pix_idx(k, 2)];
                r_win[pix_idx(k, 2)] <= w_new[k];
            end
        end
    end

    // Single-cycle pulses: window valid only for interior positions, frame end on its last pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_accept && w_interior;
            r_frame_done <= w_accept && w_last_col && w_last_row;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.frame_done    = r_frame_done;
    assign bus.input_pixel_1 = r_win[PIX_TL];
    assign bus.input_pixel_2 = r_win[PIX_TC];
    assign bus.input_pixel_3 = r_win[PIX_TR];
    assign bus.input_pixel_4 = r_win[PIX_ML];
    assign bus.input_pixel_5 = r_win[PIX_C];
    assign bus.input_pixel_6 = r_win[PIX_MR];
    assign bus.input_pixel_7 = r_win[PIX_BL];
    assign bus.input_pixel_8 = r_win[PIX_BC];
    assign bus.input_pixel_9 = r_win[PIX_BR];
endmodule

// File: tb/tb_window_3x3_generator.sv
// tb_window_3x3_generator: directed checks of the 3x3 window generator on a 5x4 frame
module tb_window_3x3_generator;
    localparam int W = 5;
    localparam int H = 4;

    typedef struct {
        int          r;
        int          c;
        logic [71:0] win;
    } vec_t;

    vec_t        tbl [6];
    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          failures = 0;
    logic [71:0] cur_win;
    logic [71:0] last_win;
    logic [71:0] win_q [$];
    int          fd_cnt = 0;
    bit          chk_en = 1'b0;
    int          m_row;
    int          m_col;
    logic        m_ov;
    logic        m_fd;
    logic        m_hold;

    window_3x3_generator_if #(.DATA_WIDTH(8)) bus ();

    window_3x3_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign cur_win = {bus.input_pixel_1, bus.input_pixel_2, bus.input_pixel_3,
                      bus.input_pixel_4, bus.input_pixel_5, bus.input_pixel_6,
                      bus.input_pixel_7, bus.input_pixel_8, bus.input_pixel_9};

    task automatic check1(input string n, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    // Position of each accepted pixel and the pulses it must produce one clock later
    always @(posedge clk) begin
        if (!rst_n) begin
            m_row  <= 0;
            m_col  <= 0;
            m_ov   <= 1'b0;
            m_fd   <= 1'b0;
            m_hold <= 1'b0;
        end else begin
            m_hold <= !bus.in_valid;
            m_ov   <= bus.in_valid && m_row >= 2 && m_col >= 2;
            m_fd   <= bus.in_valid && m_row == H - 1 && m_col == W - 1;
            if (bus.in_valid) begin
                if (m_col == W - 1) begin
                    m_col <= 0;
                    m_row <= (m_row == H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col <= m_col + 1;
                end
            end
        end
    end

    // Protocol checks and window capture away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check1("out_valid", {71'd0, bus.out_valid}, {71'd0, m_ov});
            check1("frame_done", {71'd0, bus.frame_done}, {71'd0, m_fd});
            if (m_hold) check1("window_hold", cur_win, last_win);
            if (bus.out_valid === 1'b1) win_q.push_back(cur_win);
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
        last_win = cur_win;
    end

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic feed_pixels(input logic [7:0] base, input int start, input int n, input bit gaps);
        for (int k = start; k < start + n; k++) begin
            if (gaps) for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idle();
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_pixel = base + 8'((k / W) * 16 + (k % W));
        end
    endtask

    task automatic check_frame(input int off, input logic [7:0] base);
        for (int i = 0; i < 6; i++) begin
            if (off + i < win_q.size())
                check1($sformatf("win_r%0dc%0d_base%h", tbl[i].r, tbl[i].c, base),
                       win_q[off + i], tbl[i].win | {9{base}});
        end
    endtask

    initial begin
        tbl[0] = '{2, 2, 72'h00_01_02_10_11_12_20_21_22};
        tbl[1] = '{2, 3, 72'h01_02_03_11_12_13_21_22_23};
        tbl[2] = '{2, 4, 72'h02_03_04_12_13_14_22_23_24};
        tbl[3] = '{3, 2, 72'h10_11_12_20_21_22_30_31_32};
        tbl[4] = '{3, 3, 72'h11_12_13_21_22_23_31_32_33};
        tbl[5] = '{3, 4, 72'h12_13_14_22_23_24_32_33_34};

        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_out_valid", {71'd0, bus.out_valid}, 72'd0);
        check1("reset_frame_done", {71'd0, bus.frame_done}, 72'd0);
        check1("reset_window", cur_win, 72'd0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        chk_en       = 1'b1;

        feed_pixels(8'h00, 0, W * H, 1'b0);
        repeat (3) idle();
        check1("cont_count", 72'(win_q.size()), 72'd6);
        check_frame(0, 8'h00);
        check1("cont_frame_done", 72'(fd_cnt), 72'd1);
        win_q.delete();
        fd_cnt = 0;

        feed_pixels(8'h40, 0, W * H, 1'b1);
        repeat (3) idle();
        check1("gap_count", 72'(win_q.size()), 72'd6);
        check_frame(0, 8'h40);
        check1("gap_frame_done", 72'(fd_cnt), 72'd1);
        win_q.delete();
        fd_cnt = 0;

        feed_pixels(8'h00, 0, W * H, 1'b0);
        feed_pixels(8'h80, 0, W * H, 1'b0);
        repeat (3) idle();
        check1("b2b_count", 72'(win_q.size()), 72'd12);
        check_frame(0, 8'h00);
        check_frame(6, 8'h80);
        check1("b2b_frame_done", 72'(fd_cnt), 72'd2);

        feed_pixels(8'h00, 0, 14, 1'b0);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        win_q.delete();
        fd_cnt = 0;
        feed_pixels(8'h00, 0, 10, 1'b0);
        repeat (2) idle();
        check1("midrst_no_early_window", 72'(win_q.size()), 72'd0);
        feed_pixels(8'h00, 10, 10, 1'b0);
        repeat (3) idle();
        check1("midrst_count", 72'(win_q.size()), 72'd6);
        check_frame(0, 8'h00);
        check1("midrst_frame_done", 72'(fd_cnt), 72'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
